// File: rtl/seq_engine.sv
// seq_engine: slot-table sequencer. Walks slots 0..end_cnt, programs a slave
// for every armed slot through a reprog/init/start handshake, times its run
// and writes status/profile back into the table.
module seq_engine #(
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 32,
  parameter int SIZE_W = 26,
  parameter int PROF_W = 32,
  parameter int TO_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_wr,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [2:0]        cfg_field,
  input  logic [ADDR_W-1:0] cfg_data,
  output logic              cfg_err,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_src_addr,
  output logic [ADDR_W-1:0] rd_dst_addr,
  output logic [SIZE_W-1:0] rd_src_size,
  output logic [SIZE_W-1:0] rd_dst_size,
  output logic [1:0]        rd_status,
  output logic [PROF_W-1:0] rd_profile,
  input  logic              ctrl_start,
  input  logic              ctrl_stop,
  input  logic              ctrl_loop,
  input  logic [IDX_W-1:0]  end_cnt,
  input  logic [TO_W-1:0]   timeout_limit,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IDX_W-1:0]  main_cnt,
  output logic              slave_reprog,
  input  logic              slave_reprog_ack,
  output logic              slave_init,
  input  logic              slave_init_done,
  output logic              slave_start,
  input  logic              slave_start_ack,
  input  logic              slave_fin,
  output logic [ADDR_W-1:0] slave_src_addr,
  output logic [ADDR_W-1:0] slave_dst_addr,
  output logic [SIZE_W-1:0] slave_src_size,
  output logic [SIZE_W-1:0] slave_dst_size
);

  localparam int SLOTS = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REPROG, S_INIT, S_START, S_EXEC, S_WRBACK, S_ERROR
  } state_t;

  state_t state, nxt;

  logic [ADDR_W-1:0] t_src_addr [SLOTS];
  logic [ADDR_W-1:0] t_dst_addr [SLOTS];
  logic [SIZE_W-1:0] t_src_size [SLOTS];
  logic [SIZE_W-1:0] t_dst_size [SLOTS];
  logic [1:0]        t_status   [SLOTS];
  logic [PROF_W-1:0] t_prof     [SLOTS];

  logic [PROF_W-1:0] prof_cnt;
  logic              stop_pend;
  logic              skip;        // current slot was disabled: WRBACK must not touch it
  logic              stop_now;
  logic              timeout_hit;
  logic              last;

  // A stop arriving in the WRBACK cycle itself still takes effect there.
  assign stop_now    = stop_pend | ctrl_stop;
  assign timeout_hit = (timeout_limit != '0) && (prof_cnt == PROF_W'(timeout_limit));
  assign last        = (main_cnt == end_cnt);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state and handshake outputs; handshakes decode straight from state so
  // reset drops them in the same cycle.
  always_comb begin
    nxt          = state;
    busy         = (state != S_IDLE);
    slave_reprog = 1'b0;
    slave_init   = 1'b0;
    slave_start  = 1'b0;
    case (state)
      S_IDLE:   if (ctrl_start) nxt = S_CHECK;
      S_CHECK:  nxt = (t_status[main_cnt] == 2'b00) ? S_WRBACK : S_REPROG;
      S_REPROG: begin
        slave_reprog = 1'b1;
        if (slave_reprog_ack) nxt = S_INIT;
      end
      S_INIT: begin
        slave_init = 1'b1;
        if (slave_init_done) nxt = S_START;
      end
      S_START: begin
        slave_start = 1'b1;
        if (slave_start_ack) nxt = S_EXEC;
      end
      S_EXEC: begin
        if (slave_fin)        nxt = S_WRBACK;
        else if (timeout_hit) nxt = S_ERROR;
      end
      S_WRBACK: begin
        if (stop_now)  nxt = S_IDLE;
        else if (last) nxt = ctrl_loop ? S_CHECK : S_IDLE;
        else           nxt = S_CHECK;
      end
      S_ERROR:  nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Sequencing datapath: slot pointer, run counter, sticky flags, slave regs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_cnt       <= '0;
      prof_cnt       <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      stop_pend      <= 1'b0;
      skip           <= 1'b0;
      slave_src_addr <= '0;
      slave_dst_addr <= '0;
      slave_src_size <= '0;
      slave_dst_size <= '0;
    end else begin
      if (busy && ctrl_stop) stop_pend <= 1'b1;
      case (state)
        S_IDLE: if (ctrl_start) begin
          main_cnt  <= '0;
          done      <= 1'b0;
          err       <= 1'b0;
          stop_pend <= 1'b0;
        end
        S_CHECK: begin
          skip <= (t_status[main_cnt] == 2'b00);
          if (t_status[main_cnt] != 2'b00) begin
            slave_src_addr <= t_src_addr[main_cnt];
            slave_dst_addr <= t_dst_addr[main_cnt];
            slave_src_size <= t_src_size[main_cnt];
            slave_dst_size <= t_dst_size[main_cnt];
          end
        end
        S_START: if (slave_start_ack) prof_cnt <= '0;
        // The timeout cycle does not count, so the recorded profile equals the limit.
        S_EXEC: if (nxt != S_ERROR && prof_cnt != '1) prof_cnt <= prof_cnt + 1'b1;
        S_WRBACK: begin
          if (stop_now) stop_pend <= 1'b0;
          else if (last) begin
            if (ctrl_loop) main_cnt <= '0;
            else           done     <= 1'b1;
          end else main_cnt <= main_cnt + 1'b1;
        end
        S_ERROR: err <= 1'b1;
        default: ;
      endcase
    end
  end

  // Slot table: host writes in IDLE, engine writeback, registered readback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        t_src_addr[i] <= '0;
        t_dst_addr[i] <= '0;
        t_src_size[i] <= '0;
        t_dst_size[i] <= '0;
        t_status[i]   <= '0;
        t_prof[i]     <= '0;
      end
      cfg_err     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_src_addr <= '0;
      rd_dst_addr <= '0;
      rd_src_size <= '0;
      rd_dst_size <= '0;
      rd_status   <= '0;
      rd_profile  <= '0;
    end else begin
      cfg_err  <= cfg_wr && (state != S_IDLE);
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_src_addr <= t_src_addr[rd_idx];
        rd_dst_addr <= t_dst_addr[rd_idx];
        rd_src_size <= t_src_size[rd_idx];
        rd_dst_size <= t_dst_size[rd_idx];
        rd_status   <= t_status[rd_idx];
        rd_profile  <= t_prof[rd_idx];
      end
      if (cfg_wr && state == S_IDLE) begin
        case (cfg_field)
          3'd0: t_src_addr[cfg_idx] <= cfg_data;
          3'd1: t_src_size[cfg_idx] <= cfg_data[SIZE_W-1:0];
          3'd2: t_dst_addr[cfg_idx] <= cfg_data;
          3'd3: t_dst_size[cfg_idx] <= cfg_data[SIZE_W-1:0];
          3'd4: t_status[cfg_idx]   <= cfg_data[1:0];
          default: ;
        endcase
      end
      if (state == S_WRBACK && !skip) begin
        t_status[main_cnt] <= 2'b10;
        t_prof[main_cnt]   <= prof_cnt;
      end
      if (state == S_ERROR) begin
        t_status[main_cnt] <= 2'b11;
        t_prof[main_cnt]   <= prof_cnt;
      end
    end
  end

endmodule

// File: tb/tb_seq_engine.sv
// tb_seq_engine: directed + randomized checks of seq_engine against a
// slot-level reference model (profile = slave run length, timeout rule).
module tb_seq_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [2:0]  cfg_field = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_err;
  logic        rd_req = 1'b0;
  logic [2:0]  rd_idx = '0;
  logic        rd_valid;
  logic [31:0] rd_src_addr, rd_dst_addr, rd_profile;
  logic [25:0] rd_src_size, rd_dst_size;
  logic [1:0]  rd_status;
  logic        ctrl_start = 1'b0, ctrl_stop = 1'b0, ctrl_loop = 1'b0;
  logic [2:0]  end_cnt = '0;
  logic [15:0] timeout_limit = '0;
  logic        busy, done, err;
  logic [2:0]  main_cnt;
  logic        slave_reprog, slave_reprog_ack, slave_init, slave_init_done;
  logic        slave_start, slave_start_ack;
  logic        slave_fin = 1'b0;
  logic [31:0] slave_src_addr, slave_dst_addr;
  logic [25:0] slave_src_size, slave_dst_size;

  logic init_en = 1'b1;
  assign slave_reprog_ack = slave_reprog;
  assign slave_init_done  = slave_init & init_en;
  assign slave_start_ack  = slave_start;

  seq_engine dut (
    .clk(clk), .reset(reset),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid),
    .rd_src_addr(rd_src_addr), .rd_dst_addr(rd_dst_addr), .rd_src_size(rd_src_size),
    .rd_dst_size(rd_dst_size), .rd_status(rd_status), .rd_profile(rd_profile),
    .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .ctrl_loop(ctrl_loop),
    .end_cnt(end_cnt), .timeout_limit(timeout_limit),
    .busy(busy), .done(done), .err(err), .main_cnt(main_cnt),
    .slave_reprog(slave_reprog), .slave_reprog_ack(slave_reprog_ack),
    .slave_init(slave_init), .slave_init_done(slave_init_done),
    .slave_start(slave_start), .slave_start_ack(slave_start_ack), .slave_fin(slave_fin),
    .slave_src_addr(slave_src_addr), .slave_dst_addr(slave_dst_addr),
    .slave_src_size(slave_src_size), .slave_dst_size(slave_dst_size)
  );

  always #5 clk = ~clk;

  int tests = 0, failed = 0;

  // reference slot table
  logic [31:0] m_src_addr [8], m_dst_addr [8], m_prof [8];
  logic [25:0] m_src_size [8], m_dst_size [8];
  logic [1:0]  m_status [8];
  int          dly [8];          // slave run length per slot, 0 = never finishes
  int          exp_q [$];        // slots expected to be programmed, in order
  logic        exp_done, exp_err;
  logic [2:0]  exp_main;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // slave model: checks programmed values, produces slave_fin after dly[slot] EXEC cycles
  int cur = 0, run = 0, starts_seen = 0;
  bit run_on = 0, prev_reprog = 0, prev_start = 0;
  always @(negedge clk) begin
    if (!reset) begin
      run_on = 0; prev_reprog = 0; prev_start = 0;
    end else begin
      if (slave_reprog && !prev_reprog) begin
        if (exp_q.size() == 0) chk("unexpected_reprog", 1, 0);
        else begin
          cur = exp_q.pop_front();
          chk("slave_src_addr", slave_src_addr, m_src_addr[cur]);
          chk("slave_dst_addr", slave_dst_addr, m_dst_addr[cur]);
          chk("slave_src_size", slave_src_size, m_src_size[cur]);
          chk("slave_dst_size", slave_dst_size, m_dst_size[cur]);
        end
      end
      if (slave_start && !prev_start) starts_seen++;
      prev_reprog = slave_reprog;
      prev_start  = slave_start;
      if (slave_start) begin run = 0; run_on = 1; end
      else if (run_on) run++;
    end
    slave_fin = run_on && dly[cur] != 0 && run == dly[cur];
  end

  task automatic model_set(input int idx, input int field, input logic [31:0] d);
    case (field)
      0: m_src_addr[idx] = d;
      1: m_src_size[idx] = d[25:0];
      2: m_dst_addr[idx] = d;
      3: m_dst_size[idx] = d[25:0];
      4: m_status[idx]   = d[1:0];
      default: ;
    endcase
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_src_addr[i] = 0; m_dst_addr[i] = 0; m_src_size[i] = 0;
      m_dst_size[i] = 0; m_status[i] = 0; m_prof[i] = 0;
    end
  endtask

  // one pass over slots 0..e: disabled slots skipped, armed slots either finish
  // (profile = run length) or time out once the run exceeds limit+1 cycles
  task automatic model_run(input int e, input int tl);
    exp_q.delete();
    exp_done = 1; exp_err = 0; exp_main = 3'(e);
    for (int i = 0; i <= e; i++) begin
      if (m_status[i] == 2'b00) continue;
      exp_q.push_back(i);
      if (tl != 0 && (dly[i] == 0 || dly[i] > tl + 1)) begin
        m_status[i] = 2'b11; m_prof[i] = tl;
        exp_err = 1; exp_done = 0; exp_main = 3'(i);
        break;
      end
      m_status[i] = 2'b10; m_prof[i] = dly[i];
    end
  endtask

  task automatic cfg_write(input int idx, input int field, input logic [31:0] d, input bit rej);
    @(negedge clk);
    cfg_wr = 1; cfg_idx = 3'(idx); cfg_field = 3'(field); cfg_data = d;
    @(negedge clk);
    cfg_wr = 0;
    chk("cfg_err", cfg_err, rej);
    if (!rej) model_set(idx, field, d);
  endtask

  task automatic read_check(input int idx);
    @(negedge clk);
    rd_req = 1; rd_idx = 3'(idx);
    @(negedge clk);
    rd_req = 0;
    chk("rd_valid", rd_valid, 1);
    chk("rd_src_addr", rd_src_addr, m_src_addr[idx]);
    chk("rd_dst_addr", rd_dst_addr, m_dst_addr[idx]);
    chk("rd_src_size", rd_src_size, m_src_size[idx]);
    chk("rd_dst_size", rd_dst_size, m_dst_size[idx]);
    chk("rd_status", rd_status, m_status[idx]);
    chk("rd_profile", rd_profile, m_prof[idx]);
  endtask

  task automatic pulse_start();
    @(negedge clk); ctrl_start = 1;
    @(negedge clk); ctrl_start = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic check_end();
    chk("busy", busy, 0);
    chk("done", done, exp_done);
    chk("err", err, exp_err);
    chk("main_cnt", main_cnt, exp_main);
    chk("all_slots_programmed", exp_q.size(), 0);
    for (int i = 0; i < 8; i++) read_check(i);
  endtask

  task automatic run_check(input int e, input int tl);
    model_run(e, tl);
    end_cnt = 3'(e); timeout_limit = 16'(tl); ctrl_loop = 0;
    pulse_start();
    wait_idle();
    check_end();
  endtask

  task automatic arm(input logic [7:0] mask);
    for (int i = 0; i < 8; i++) begin
      cfg_write(i, 0, $urandom, 0);
      cfg_write(i, 4, {31'd0, mask[i]}, 0);
    end
  endtask

  initial begin
    logic [31:0] old, nw;
    int e, tl;
    model_clear();
    for (int i = 0; i < 8; i++) dly[i] = 1;
    repeat (2) @(negedge clk);
    // reset state
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_main_cnt", main_cnt, 0); chk("rst_reprog", slave_reprog, 0);
    chk("rst_slave_src", slave_src_addr, 0); chk("rst_rd_valid", rd_valid, 0);
    reset = 1;
    read_check(0);

    // three armed slots, immediate handshakes, 5-cycle runs
    arm(8'b0000_0111);
    for (int i = 0; i < 8; i++) dly[i] = 5;
    run_check(2, 0);

    // disabled middle slot is skipped
    arm(8'b0000_0101);
    run_check(2, 0);

    // timeout on slot 0 with a slave that never finishes
    arm(8'b0000_0001);
    dly[0] = 0;
    run_check(2, 4);

    // boundary: finish coincides with the timeout cycle, finish wins
    arm(8'b0000_0001);
    dly[0] = 5;
    run_check(0, 4);

    // loop mode, stop during slot 0 of the second pass
    arm(8'b0000_0011);
    dly[0] = 6; dly[1] = 6;
    model_run(1, 0);
    exp_q.push_back(0);
    exp_done = 0; exp_main = 0;
    starts_seen = 0;
    end_cnt = 1; ctrl_loop = 1; timeout_limit = 0;
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      if (starts_seen >= 3) break;
      @(negedge clk);
    end
    chk("third_start_seen", starts_seen, 3);
    @(negedge clk); ctrl_stop = 1;
    @(negedge clk); ctrl_stop = 0;
    wait_idle();
    ctrl_loop = 0;
    check_end();

    // same-cycle write and read of one slot returns pre-write contents
    old = m_src_addr[3]; nw = $urandom;
    @(negedge clk);
    cfg_wr = 1; cfg_idx = 3; cfg_field = 0; cfg_data = nw; rd_req = 1; rd_idx = 3;
    @(negedge clk);
    cfg_wr = 0; rd_req = 0;
    chk("rd_prewrite", rd_src_addr, old);
    model_set(3, 0, nw);
    read_check(3);

    // config write and start while busy are rejected/ignored
    arm(8'b0000_0001);
    dly[0] = 40;
    model_run(0, 0);
    end_cnt = 0; timeout_limit = 0;
    pulse_start();
    cfg_write(0, 0, ~m_src_addr[0], 1);
    @(negedge clk);
    chk("cfg_err_one_cycle", cfg_err, 0);
    pulse_start();
    read_check(5);
    wait_idle();
    check_end();

    // randomized rounds
    for (int r = 0; r < 20; r++) begin
      for (int w = 0; w < int'($urandom_range(3, 12)); w++)
        cfg_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom, 0);
      e  = $urandom_range(0, 7);
      tl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
      for (int i = 0; i < 8; i++) begin
        dly[i] = $urandom_range(1, 10);
        if (tl != 0 && $urandom_range(0, 3) == 0) dly[i] = 0;
      end
      run_check(e, tl);
    end

    // reset while stalled in INIT drops handshake at once, clears table
    arm(8'b0000_0001);
    model_run(0, 0);
    init_en = 0;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      if (slave_init) break;
      @(negedge clk);
    end
    chk("reached_init", slave_init, 1);
    reset = 0;
    #1;
    chk("rst_init_drop", slave_init, 0);
    chk("rst_busy_drop", busy, 0);
    chk("rst_slave_addr", slave_src_addr, 0);
    @(negedge clk);
    reset = 1; init_en = 1;
    exp_q.delete();
    model_clear();
    read_check(0);
    read_check(7);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seq_engine.md
SEQ_ENGINE -- requirements
Module: seq_engine

Interface
REQ-001 SHALL have parameter IDX_W, default 3, slot index width (2^IDX_W slots).
REQ-002 SHALL have parameter ADDR_W, default 32, src/dst address width.
REQ-003 SHALL have parameter SIZE_W, default 26, src/dst size width.
REQ-004 SHALL have parameter PROF_W, default 32, profile counter width.
REQ-005 SHALL have parameter TO_W, default 16, timeout limit width.
REQ-006 clk  input  1  sole clock; all logic rising-edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 cfg_wr  input  1  config write strobe.
REQ-009 cfg_idx  input  IDX_W  target slot.
REQ-010 cfg_field  input  3  0=src_addr 1=src_size 2=dst_addr 3=dst_size 4=status; 5-7 ignored.
REQ-011 cfg_data  input  ADDR_W  write data, LSB-aligned, truncated to field width.
REQ-012 cfg_err  output  1  one-cycle pulse: write rejected.
REQ-013 rd_req / rd_idx  input  1 / IDX_W  readback request / slot.
REQ-014 rd_valid  output  1; rd_src_addr, rd_dst_addr ADDR_W; rd_src_size, rd_dst_size SIZE_W; rd_status 2; rd_profile PROF_W; all outputs.
REQ-015 ctrl_start, ctrl_stop, ctrl_loop  input  1 each  start pulse, stop pulse, loop-mode level.
REQ-016 end_cnt  input  IDX_W  last slot index; timeout_limit  input  TO_W  (0 = disabled).
REQ-017 busy, done, err  output  1; main_cnt  output  IDX_W.
REQ-018 slave_reprog/slave_reprog_ack, slave_init/slave_init_done, slave_start/slave_start_ack: output/input pairs, 1 bit; slave_fin  input  1.
REQ-019 slave_src_addr, slave_dst_addr ADDR_W; slave_src_size, slave_dst_size SIZE_W  outputs, registered.

Function
REQ-020 Slot table SHALL hold per slot: src/dst addr, src/dst size, status (00 disabled, 01 armed, 10 done, 11 timeout), profile.
REQ-021 cfg_wr SHALL update the table only while state=IDLE; otherwise table unchanged and cfg_err pulses next cycle.
REQ-022 rd_req SHALL yield rd_valid plus slot contents exactly one cycle later, any state; same-cycle cfg_wr to same slot returns pre-write contents.
REQ-023 FSM states: IDLE, CHECK, REPROG, INIT, START, EXEC, WRBACK, ERROR; busy = state != IDLE.
REQ-024 IDLE: ctrl_start -> CHECK, main_cnt=0, done=0, err=0, pending stop cleared; ctrl_start when busy ignored.
REQ-025 CHECK (1 cycle): slot[main_cnt] status 00 -> WRBACK without status/profile update; else load slave_* outputs from slot, -> REPROG.
REQ-026 REPROG/INIT/START: hold slave_reprog / slave_init / slave_start high until matching ack/done sampled high, then advance next cycle; ack may arrive same cycle as assertion.
REQ-027 START->EXEC SHALL clear the profile counter; EXEC increments it each cycle, saturating at all-ones.
REQ-028 EXEC: slave_fin -> WRBACK; else if timeout_limit!=0 and counter==timeout_limit -> ERROR; slave_fin wins when both occur.
REQ-029 WRBACK (1 cycle, executed slots only): status=10, profile=counter.
REQ-030 WRBACK exit: stop pending -> IDLE; else main_cnt==end_cnt -> (ctrl_loop ? main_cnt=0, CHECK : done=1, IDLE); else main_cnt+1, CHECK.
REQ-031 ctrl_stop SHALL latch while busy and act only at WRBACK; ignored in IDLE.
REQ-032 ERROR (1 cycle): slot status=11, profile=counter, err=1, -> IDLE.
REQ-033 done and err SHALL stay sticky until next accepted ctrl_start.
REQ-034 slave_* address/size outputs SHALL stay stable from CHECK load until next load.

Reset
REQ-035 reset low SHALL asynchronously force IDLE, all table fields 0 (all slots disabled), main_cnt 0, counters 0, every output 0.
REQ-036 Reset mid-operation SHALL drop all slave_* handshakes in the same cycle; no table writeback.

Verification
REQ-037 Slots 0-2 armed, end_cnt=2, ack/done/start_ack immediate, fin 5 cycles after start -> slots 0-2 status 10, profile 5, done=1, main_cnt=2.
REQ-038 Slot 1 status 00, end_cnt=2 -> slot 1 never drives slave_reprog, status stays 00, slots 0 and 2 reach 10.
REQ-039 timeout_limit=4, slave_fin never asserted on slot 0 -> slot 0 status 11, profile 4, err=1, busy=0.
REQ-040 ctrl_loop=1, end_cnt=1, ctrl_stop during slot 0 EXEC of second pass -> slot 0 finishes WRBACK, then IDLE, done=0.
REQ-041 cfg_wr while busy -> cfg_err pulse, readback unchanged; reset asserted in INIT -> slave_init=0 immediately, busy=0.
